// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter with TX FIFO and register file.
// Register map, CTRL/STATUS bit positions, FSM encoding and divisor floor.
package uart_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_TXDATA = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_DIV_LO = 3'd3;
    localparam logic [2:0] ADDR_DIV_HI = 3'd4;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_STOP2    = 1;
    localparam int CTRL_PAR_EN   = 2;
    localparam int CTRL_PAR_ODD  = 3;
    localparam int CTRL_FLUSH    = 4;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_OVF      = 3;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a flush that wins over push.
// A push into a full FIFO is accepted only when a pop happens alongside it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rptr];

    // storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wptr] <= din;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo_regfile.sv
// UART transmitter fed by a TX FIFO, configured through a small register file.
// Define UART_PARITY_EN to build the optional parity bit and CTRL b2/b3.
module uart_tx_fifo_regfile
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       tx_out,
    output logic       irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              tx_en;
    logic              stop2;
    logic              par_en;
    logic              par_odd;
    logic [15:0]       div;
    logic              ovf;

    logic              flush;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] fdout;
    logic [CW-1:0]     fcount;
    logic              ffull;
    logic              fempty;
    logic [3:0]        cnt_sat;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       cnt;
    logic [15:0]       div_l;
    logic [3:0]        bidx;
    logic [DATA_W-1:0] shr;
    logic              stop2_l;
    logic              go;
    logic              bit_end;
    logic              adv;
    logic              busy;
    logic              tx_nxt;
    logic [7:0]        rd_mux;

`ifdef UART_PARITY_EN
    logic              par_l;
    logic              par_bit;
`endif

    assign flush   = wr_en && (wr_addr == ADDR_CTRL) && wr_data[CTRL_FLUSH];
    assign push    = wr_en && (wr_addr == ADDR_TXDATA) && !flush;
    assign go      = tx_en && !fempty;
    assign bit_end = (cnt == 16'd0);
    assign pop     = (state_nxt == S_START) && (state != S_START);
    assign adv     = pop || ((state != S_IDLE) && bit_end);
    assign cnt_sat = (fcount > CW'(15)) ? 4'hF : 4'(fcount);
    assign irq     = ovf || (tx_en && fempty && !busy);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wr_data[DATA_W-1:0]),
        .dout  (fdout),
        .count (fcount),
        .full  (ffull),
        .empty (fempty)
    );

    // control and divisor registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_en <= 1'b0;
            stop2 <= 1'b0;
            div   <= 16'(DEFAULT_DIV);
`ifdef UART_PARITY_EN
            par_en  <= 1'b0;
            par_odd <= 1'b0;
`endif
        end else if (wr_en) begin
            if (wr_addr == ADDR_CTRL) begin
                tx_en <= wr_data[CTRL_TX_EN];
                stop2 <= wr_data[CTRL_STOP2];
`ifdef UART_PARITY_EN
                par_en  <= wr_data[CTRL_PAR_EN];
                par_odd <= wr_data[CTRL_PAR_ODD];
`endif
            end
            if (wr_addr == ADDR_DIV_LO) begin
                div[7:0] <= wr_data;
            end
            if (wr_addr == ADDR_DIV_HI) begin
                div[15:8] <= wr_data;
            end
        end
    end

`ifndef UART_PARITY_EN
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    // sticky overflow, cleared by a STATUS read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (push && ffull && !pop) begin
            ovf <= 1'b1;
        end else if (rd_en && (rd_addr == ADDR_STATUS)) begin
            ovf <= 1'b0;
        end
    end

    // read mux
    always_comb begin
        rd_mux = 8'h00;
        case (rd_addr)
            ADDR_CTRL:   rd_mux = {4'b0, par_odd, par_en, stop2, tx_en};
            ADDR_STATUS: rd_mux = {cnt_sat, ovf, ffull, fempty, busy};
            ADDR_DIV_LO: rd_mux = div[7:0];
            ADDR_DIV_HI: rd_mux = div[15:8];
            default:     rd_mux = 8'h00;
        endcase
    end

    // registered read data, held while rd_en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (go) state_nxt = S_START;
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bidx == 4'(DATA_W - 1))) begin
`ifdef UART_PARITY_EN
                    state_nxt = par_l ? S_PARITY : S_STOP1;
`else
                    state_nxt = S_STOP1;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_nxt = S_STOP1;
            end
`endif
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2_l) state_nxt = S_STOP2;
                    else         state_nxt = go ? S_START : S_IDLE;
                end
            end
            S_STOP2: begin
                if (bit_end) state_nxt = go ? S_START : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and next serial level at bit boundaries
    always_comb begin
        busy   = (state != S_IDLE);
        tx_nxt = tx_out;
        if (adv) begin
            unique case (state_nxt)
                S_START: tx_nxt = 1'b0;
                S_DATA:  tx_nxt = (state == S_START) ? shr[0] : shr[1];
`ifdef UART_PARITY_EN
                S_PARITY: tx_nxt = par_bit;
`endif
                default: tx_nxt = 1'b1;
            endcase
        end
    end

    // baud counter, shifter and per-frame configuration snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 16'd0;
            div_l   <= MIN_DIV;
            bidx    <= 4'd0;
            shr     <= '0;
            stop2_l <= 1'b0;
`ifdef UART_PARITY_EN
            par_l   <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else if (pop) begin
            cnt     <= eff_div(div) - 16'd1;
            div_l   <= eff_div(div);
            bidx    <= 4'd0;
            shr     <= fdout;
            stop2_l <= stop2;
`ifdef UART_PARITY_EN
            par_l   <= par_en;
            par_bit <= (^fdout) ^ par_odd;
`endif
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                cnt <= div_l - 16'd1;
                if (state == S_DATA) begin
                    shr  <= shr >> 1;
                    bidx <= bidx + 4'd1;
                end
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

    // registered serial output, idle high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_out <= 1'b1;
        end else begin
            tx_out <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_regfile.sv
// Directed self-checking bench for uart_tx_fifo_regfile.
// Covers reset, register map, framing, FIFO overflow and mid-frame control.
module tb_uart_tx_fifo_regfile;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_TXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_DIV_LO = 3'd3;
    localparam logic [2:0] A_DIV_HI = 3'd4;

`ifdef UART_PARITY_EN
    localparam bit         PAR      = 1'b1;
    localparam logic [7:0] CTRL_RB  = 8'h0F;
`else
    localparam bit         PAR      = 1'b0;
    localparam logic [7:0] CTRL_RB  = 8'h03;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic       tx_out;
    logic       irq;

    int checks = 0;
    int failures = 0;
    logic [7:0] s;

    always #5 clk = ~clk;

    uart_tx_fifo_regfile #(
        .DATA_W      (8),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (5208)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx_out  (tx_out),
        .irq     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
    endtask

    task automatic idle_check(input string tag, input int n);
        int ok;
        ok = 0;
        for (int c = 0; c < n; c++) begin
            if (tx_out === 1'b1) ok++;
            @(negedge clk);
        end
        chk(tag, ok, n);
    endtask

    task automatic send_check(input logic [7:0] b, input int div,
                              input bit par, input bit odd,
                              input bit st2, input bit wt);
        logic [11:0] bits;
        int n;
        int ok;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        n = 9;
        if (par) begin
            bits[n] = (^b) ^ odd;
            n = n + 1;
        end
        bits[n] = 1'b1;
        n = n + 1;
        if (st2) begin
            bits[n] = 1'b1;
            n = n + 1;
        end
        if (wt) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            ok = 0;
            for (int c = 0; c < div; c++) begin
                if (tx_out === bits[k]) ok++;
                @(negedge clk);
            end
            chk($sformatf("b%02h_bit%0d", b, k), ok, div);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with random register traffic
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 3'($urandom_range(0, 7));
            chk("rst_hold", {tx_out, rd_data, irq}, {1'b1, 8'h00, 1'b0});
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;

        // register map
        rd(A_STATUS, s); chk("status_rst", s, 8'h02);
        rd(A_CTRL, s);   chk("ctrl_rst", s, 8'h00);
        rd(A_DIV_HI, s); chk("divhi_rst", s, 8'h14);
        rd(A_DIV_LO, s); chk("divlo_rst", s, 8'h58);
        @(negedge clk);
        chk("rd_hold", rd_data, 8'h58);
        wr(A_DIV_LO, 8'h58); wr(A_DIV_HI, 8'h14);
        rd(A_DIV_LO, s); chk("divlo_rb", s, 8'h58);
        rd(A_DIV_HI, s); chk("divhi_rb", s, 8'h14);
        wr(3'd5, 8'hFF);
        rd(3'd5, s);     chk("addr5", s, 8'h00);
        rd(A_TXDATA, s); chk("txdata_rd", s, 8'h00);
        rd(A_STATUS, s); chk("status_nopush", s, 8'h02);
        chk("irq_off", irq, 1'b0);

        // single frame at divisor 16
        wr(A_DIV_LO, 8'd16); wr(A_DIV_HI, 8'd0); wr(A_CTRL, 8'h01);
        chk("irq_idle_en", irq, 1'b1);
        wr(A_TXDATA, 8'hA5);
        chk("pre_start", tx_out, 1'b1);
        fork
            send_check(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                chk("irq_busy", irq, 1'b0);
                rd(A_STATUS, s); chk("status_busy", s, 8'h03);
            end
        join
        chk("irq_done", irq, 1'b1);
        rd(A_STATUS, s); chk("status_done", s, 8'h02);

        // stop2, plus parity when built in
        wr(A_DIV_LO, 8'd8); wr(A_CTRL, 8'h1F);
        rd(A_CTRL, s); chk("ctrl_rb", s, CTRL_RB);
        wr(A_TXDATA, 8'h03);
        send_check(8'h03, 8, PAR, 1'b1, 1'b1, 1'b1);
        idle_check("idle_stop2", 10);
        wr(A_CTRL, 8'h01); wr(A_DIV_LO, 8'd16);

        // FIFO fill and overflow
        wr(A_CTRL, 8'h00);
        for (int i = 0; i < 8; i++) wr(A_TXDATA, 8'(8'h10 + i));
        chk("irq_full", irq, 1'b0);
        wr(A_TXDATA, 8'hEE);
        chk("irq_ovf", irq, 1'b1);
        rd(A_STATUS, s); chk("status_ovf", s, 8'h8C);
        rd(A_STATUS, s); chk("status_ovf_clr", s, 8'h84);
        chk("irq_ovf_clr", irq, 1'b0);
        idle_check("idle_disabled", 8);
        wr(A_CTRL, 8'h01);
        for (int i = 0; i < 8; i++)
            send_check(8'(8'h10 + i), 16, 1'b0, 1'b0, 1'b0, i == 0);
        chk("irq_drained", irq, 1'b1);
        rd(A_STATUS, s); chk("status_drained", s, 8'h02);

        // mid-frame divisor change and tx_en clear
        wr(A_TXDATA, 8'h5A);
        fork
            send_check(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                wr(A_TXDATA, 8'hC3);
                wr(A_DIV_LO, 8'd32);
                wr(A_CTRL, 8'h00);
                rd(A_STATUS, s); chk("status_mid", s, 8'h11);
            end
        join
        idle_check("idle_held", 40);
        rd(A_STATUS, s); chk("status_held", s, 8'h10);
        chk("irq_held", irq, 1'b0);
        wr(A_CTRL, 8'h01);
        send_check(8'hC3, 32, 1'b0, 1'b0, 1'b0, 1'b1);

        // flush during a frame
        wr(A_TXDATA, 8'h11);
        fork
            send_check(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                wr(A_TXDATA, 8'h22);
                wr(A_TXDATA, 8'h33);
                wr(A_CTRL, 8'h11);
                rd(A_STATUS, s); chk("status_flush", s, 8'h03);
            end
        join
        idle_check("idle_flushed", 20);
        rd(A_STATUS, s); chk("status_flushed", s, 8'h02);
        rd(A_CTRL, s);   chk("ctrl_noflush", s, 8'h01);

        // divisor below floor runs at 4 cycles per bit
        wr(A_DIV_LO, 8'd2);
        rd(A_DIV_LO, s); chk("divlo_raw", s, 8'h02);
        wr(A_TXDATA, 8'h81);
        send_check(8'h81, 4, 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset during a start bit
        wr(A_TXDATA, 8'h00);
        @(negedge clk);
        chk("abort_start", tx_out, 1'b0);
        #2 rst = 1'b0;
        #1 chk("abort_tx", tx_out, 1'b1);
        chk("abort_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        rd(A_STATUS, s); chk("status_abort", s, 8'h02);
        idle_check("idle_abort", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
